// File: rtl/ast_pkg.sv
// Shared types and helpers for the Avalon-ST packet source.
package ast_pkg;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  // Width of the empty field; never narrower than one bit.
  function automatic int empty_w(input int spb);
    return (spb > 1) ? $clog2(spb) : 1;
  endfunction

  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/ast_pkt_source_if.sv
// Avalon-ST beat bus between a packet source (master) and a sink (slave).
interface ast_pkt_source_if #(
  parameter int WIDTH   = 32,
  parameter int EMPTY_W = 2
);
  logic               valid;
  logic               ready;
  logic               sop;
  logic               eop;
  logic [WIDTH-1:0]   data;
  logic [EMPTY_W-1:0] empty;

  modport master (output valid, data, sop, eop, empty, input ready);
  modport slave  (input valid, data, sop, eop, empty, output ready);
endinterface

// File: rtl/ast_skid_buf.sv
// Two-entry FIFO holding fetched words until a transfer slot takes them.
module ast_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       count_o
);
  logic [1:0][WIDTH-1:0] mem_q, mem_d;
  logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/ast_pkt_source.sv
// Avalon-ST packet source: fetches words from an upstream FIFO into a skid buffer
// and frames them as sop/eop/empty beats, honouring the sink's READY_LATENCY.
module ast_pkt_source
  import ast_pkg::*;
#(
  parameter int DATABITS_PER_SYMBOL = 8,
  parameter int SYMBOLS_PER_BEAT    = 4,
  parameter int WIDTH               = DATABITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
  parameter int READY_LATENCY       = 3,
  parameter int LEN_W               = 16,
  parameter int EMPTY_W             = empty_w(SYMBOLS_PER_BEAT)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] pkt_len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             fifo_rd_o,
  input  logic [WIDTH-1:0] fifo_data_i,
  input  logic             fifo_non_empty_i,
  ast_pkt_source_if.master ast
);
  localparam int unsigned SPB = SYMBOLS_PER_BEAT;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   beats_q, beats_d, fetch_cnt_q, fetch_cnt_d, xfer_cnt_q, xfer_cnt_d;
  logic [EMPTY_W-1:0] pad_q, pad_d;
  logic               in_flight_q, done_q;
  logic [1:0]         buf_cnt;
  logic [WIDTH-1:0]   buf_head;
  logic [2:0]         occ_next;
  logic               accept, pop, eop_xfer, beat_sop, beat_eop;

  assign accept   = (state_q == IDLE) && start_i && (pkt_len_i != '0);
  assign beat_sop = (xfer_cnt_q == '0);
  assign beat_eop = (xfer_cnt_q == beats_q - LEN_W'(1));
  // Occupancy once this cycle's pop and the in-flight read have settled.
  assign occ_next = 3'(buf_cnt) + 3'(in_flight_q) - 3'(pop);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SEND;
      SEND:    if (eop_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state_q == SEND);
    fifo_rd_o = (state_q == SEND) && fifo_non_empty_i &&
                (fetch_cnt_q < beats_q) && (occ_next < 3'd2);
  end

  always_comb begin
    beats_d     = beats_q;
    pad_d       = pad_q;
    fetch_cnt_d = fetch_cnt_q;
    xfer_cnt_d  = xfer_cnt_q;
    if (accept) begin
      beats_d     = LEN_W'(ceil_div(32'(pkt_len_i), SPB));
      pad_d       = EMPTY_W'(ceil_div(32'(pkt_len_i), SPB) * SPB - 32'(pkt_len_i));
      fetch_cnt_d = '0;
      xfer_cnt_d  = '0;
    end else begin
      if (fifo_rd_o) fetch_cnt_d = fetch_cnt_q + LEN_W'(1);
      if (pop)       xfer_cnt_d  = xfer_cnt_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      beats_q     <= '0;
      pad_q       <= '0;
      fetch_cnt_q <= '0;
      xfer_cnt_q  <= '0;
      in_flight_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      beats_q     <= beats_d;
      pad_q       <= pad_d;
      fetch_cnt_q <= fetch_cnt_d;
      xfer_cnt_q  <= xfer_cnt_d;
      in_flight_q <= fifo_rd_o;
      done_q      <= eop_xfer;
    end
  end

  assign done_o = done_q;

  ast_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (in_flight_q),
    .push_data_i (fifo_data_i),
    .pop_i       (pop),
    .head_o      (buf_head),
    .count_o     (buf_cnt)
  );

  if (READY_LATENCY == 0) begin : g_rl0
    // Head of the buffer is presented directly and held until ready.
    assign ast.valid = (state_q == SEND) && (buf_cnt != 2'd0);
    assign pop       = ast.valid && ast.ready;
    assign eop_xfer  = pop && beat_eop;
    assign ast.data  = ast.valid ? buf_head : '0;
    assign ast.sop   = ast.valid && beat_sop;
    assign ast.eop   = ast.valid && beat_eop;
    assign ast.empty = (ast.valid && beat_eop) ? pad_q : '0;
  end else begin : g_rl
    localparam int HW = (READY_LATENCY > 1) ? READY_LATENCY - 1 : 1;
    logic [HW-1:0]      hist_q;
    logic               grant_next;
    logic               vld_q, vld_d, sop_q, sop_d, eop_q, eop_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [EMPTY_W-1:0] empty_q, empty_d;

    // Outputs are registered, so decide one cycle early: next cycle's slot
    // belongs to the ready sampled READY_LATENCY-1 cycles before now.
    assign grant_next = (READY_LATENCY == 1) ? ast.ready : hist_q[HW-1];
    assign pop        = grant_next && (state_q == SEND) && (buf_cnt != 2'd0);
    assign eop_xfer   = vld_q && eop_q;

    always_comb begin
      vld_d   = 1'b0;
      data_d  = '0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      empty_d = '0;
      if (pop) begin
        vld_d   = 1'b1;
        data_d  = buf_head;
        sop_d   = beat_sop;
        eop_d   = beat_eop;
        empty_d = beat_eop ? pad_q : '0;
      end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        hist_q  <= '0;
        vld_q   <= 1'b0;
        data_q  <= '0;
        sop_q   <= 1'b0;
        eop_q   <= 1'b0;
        empty_q <= '0;
      end else begin
        hist_q  <= (hist_q << 1) | HW'(ast.ready);
        vld_q   <= vld_d;
        data_q  <= data_d;
        sop_q   <= sop_d;
        eop_q   <= eop_d;
        empty_q <= empty_d;
      end
    end

    assign ast.valid = vld_q;
    assign ast.data  = data_q;
    assign ast.sop   = sop_q;
    assign ast.eop   = eop_q;
    assign ast.empty = empty_q;
  end
endmodule
